// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_ext family: request-mode constants,
// the per-cycle operation decode and the count-width helper.
package fifo_pkg;

  localparam int LEVEL_MODE = 0;
  localparam int EDGE_MODE  = 1;

  // Outcome of one cycle's flush/push/drop decision
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_FLUSH,
    OP_PUSH,
    OP_DROP,
    OP_BOTH,
    OP_PUSH_UNF,
    OP_UNF,
    OP_OVF
  } fifo_op_e;

  // Count must hold 0..depth inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_edge_det.sv
// Rising-edge detector: one flop of delay, pulse is combinational so no
// latency is added to the request.
module fifo_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_d;

  // Delayed copy of the level input, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) level_d <= 1'b0;
    else      level_d <= level;
  end

  assign pulse = level & ~level_d;

endmodule

// File: rtl/fifo_ext.sv
// Circular FIFO with arbitrary depth, optional edge-sensitive requests,
// thresholds, sticky error flags, synchronous flush and optional
// registered output.
module fifo_ext #(
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_DEPTH = 64,
  parameter  int EDGE_MODE  = 0,
  parameter  int REG_OUT    = 0,
  localparam int CW         = fifo_pkg::cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  drop,
  input  logic                  flush,
  input  logic                  clear_err,
  input  logic [CW-1:0]         afull_th,
  input  logic [CW-1:0]         aempty_th,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         awaiting_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef logic [PW-1:0] ptr_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  ptr_t                  wr_ptr, rd_ptr, wr_inc, rd_inc;
  logic [CW-1:0]         count;
  logic                  p, d;
  fifo_pkg::fifo_op_e    op;
  logic                  wr_en, rd_en, set_ovf, set_unf;

  // Explicit wrap so non-power-of-two depths work
  function automatic ptr_t ptr_next(input ptr_t ptr);
    return (ptr == PW'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  if (EDGE_MODE == fifo_pkg::EDGE_MODE) begin : g_edge
    fifo_edge_det u_push_det (.clk(clk), .rst(rst), .level(push), .pulse(p));
    fifo_edge_det u_drop_det (.clk(clk), .rst(rst), .level(drop), .pulse(d));
  end else begin : g_level
    assign p = push;
    assign d = drop;
  end

  assign wr_inc     = ptr_next(wr_ptr);
  assign rd_inc     = ptr_next(rd_ptr);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));

  // Per-cycle decision; flush dominates, then empty/full corner cases
  always_comb begin
    op = fifo_pkg::OP_IDLE;
    if (flush) begin
      op = fifo_pkg::OP_FLUSH;
    end else if (fifo_empty) begin
      if (p && d)  op = fifo_pkg::OP_PUSH_UNF;
      else if (d)  op = fifo_pkg::OP_UNF;
      else if (p)  op = fifo_pkg::OP_PUSH;
    end else if (fifo_full) begin
      if (p && d)  op = fifo_pkg::OP_BOTH;
      else if (p)  op = fifo_pkg::OP_OVF;
      else if (d)  op = fifo_pkg::OP_DROP;
    end else begin
      if (p && d)  op = fifo_pkg::OP_BOTH;
      else if (p)  op = fifo_pkg::OP_PUSH;
      else if (d)  op = fifo_pkg::OP_DROP;
    end
  end

  assign wr_en   = op inside {fifo_pkg::OP_PUSH, fifo_pkg::OP_BOTH, fifo_pkg::OP_PUSH_UNF};
  assign rd_en   = op inside {fifo_pkg::OP_DROP, fifo_pkg::OP_BOTH};
  assign set_ovf = (op == fifo_pkg::OP_OVF);
  assign set_unf = op inside {fifo_pkg::OP_UNF, fifo_pkg::OP_PUSH_UNF};

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (op == fifo_pkg::OP_FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_inc;
      if (rd_en) rd_ptr <= rd_inc;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error wins over a coincident clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= set_ovf | (overflow  & ~clear_err);
      underflow <= set_unf | (underflow & ~clear_err);
    end
  end

  // Storage array, no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_i;
  end

  assign almost_full    = (count >= afull_th);
  assign almost_empty   = (count <= aempty_th);
  assign awaiting_count = count;

  if (REG_OUT != 0) begin : g_reg_out
    logic [DATA_WIDTH-1:0] data_q;

    // Output flop preloads the head the combinational path would show next:
    // incoming data when it becomes the head, else the entry after read_ptr.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        data_q <= '0;
      else if (op == fifo_pkg::OP_FLUSH)
        data_q <= '0;
      else if (wr_en && (fifo_empty || (rd_en && count == CW'(1))))
        data_q <= data_i;
      else if (rd_en && count >= CW'(2))
        data_q <= mem[rd_inc];
    end

    assign data_o = data_q;
  end else begin : g_comb_out
    assign data_o = mem[rd_ptr];
  end

endmodule

// File: tb/tb_fifo_ext.sv
// Self-checking bench for fifo_ext: three configurations (depth 5 level,
// depth 8 level, depth 5 edge), each built with REG_OUT=0 and REG_OUT=1,
// all driven by the same stimulus and checked against a queue scoreboard.
module tb_fifo_ext;

  localparam int DW = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_i;
  logic          push, drop, flush, clear_err;
  logic [TW-1:0] afull_th, aempty_th;

  logic [DW-1:0] dout [6];
  logic [TW-1:0] cnt  [6];
  logic          emp [6], ful [6], af [6], ae [6], ovf [6], unf [6];

  int checks   = 0;
  int failures = 0;

  // Scoreboard state per configuration group
  logic [DW-1:0] mq [3][$];
  bit            movf [3], munf [3], pprev [3], dprev [3];
  int            mdepth [3] = '{5, 8, 5};
  bit            medge  [3] = '{1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  for (genvar i = 0; i < 6; i++) begin : g_dut
    fifo_ext #(
      .DATA_WIDTH(DW),
      .FIFO_DEPTH((i / 2 == 1) ? 8 : 5),
      .EDGE_MODE ((i / 2 == 2) ? 1 : 0),
      .REG_OUT   (i % 2)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .data_i        (data_i),
      .push          (push),
      .data_o        (dout[i]),
      .drop          (drop),
      .flush         (flush),
      .clear_err     (clear_err),
      .afull_th      (afull_th),
      .aempty_th     (aempty_th),
      .fifo_empty    (emp[i]),
      .fifo_full     (ful[i]),
      .almost_full   (af[i]),
      .almost_empty  (ae[i]),
      .awaiting_count(cnt[i]),
      .overflow      (ovf[i]),
      .underflow     (unf[i])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic post_check();
    int g, sz;
    for (int i = 0; i < 6; i++) begin
      g  = i / 2;
      sz = mq[g].size();
      check_eq($sformatf("count[%0d]", i), 32'(cnt[i]), 32'(sz));
      check_eq($sformatf("empty[%0d]", i), 32'(emp[i]), 32'(sz == 0));
      check_eq($sformatf("full[%0d]", i),  32'(ful[i]), 32'(sz == mdepth[g]));
      check_eq($sformatf("afull[%0d]", i), 32'(af[i]),  32'(sz >= int'(afull_th)));
      check_eq($sformatf("aempty[%0d]", i), 32'(ae[i]), 32'(sz <= int'(aempty_th)));
      check_eq($sformatf("ovf[%0d]", i),   32'(ovf[i]), 32'(movf[g]));
      check_eq($sformatf("unf[%0d]", i),   32'(unf[i]), 32'(munf[g]));
      if (sz > 0) check_eq($sformatf("head[%0d]", i), 32'(dout[i]), 32'(mq[g][0]));
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < 3; g++) begin
      mq[g].delete();
      movf[g]  = 1'b0;
      munf[g]  = 1'b0;
      pprev[g] = 1'b0;
      dprev[g] = 1'b0;
    end
  endtask

  task automatic regout_zero_check(input string tag);
    for (int i = 1; i < 6; i += 2)
      check_eq($sformatf("%s[%0d]", tag, i), 32'(dout[i]), 32'h0);
  endtask

  task automatic pop_check(input int g);
    logic [DW-1:0] exp;
    exp = mq[g].pop_front();
    check_eq($sformatf("pop[%0d]", 2 * g),     32'(dout[2 * g]),     32'(exp));
    check_eq($sformatf("pop[%0d]", 2 * g + 1), 32'(dout[2 * g + 1]), 32'(exp));
  endtask

  task automatic step(input bit p, input bit d, input logic [DW-1:0] din,
                      input bit fl, input bit ce);
    bit ep, ed, so, su;
    int sz;
    @(negedge clk);
    push = p; drop = d; data_i = din; flush = fl; clear_err = ce;
    #1;
    for (int g = 0; g < 3; g++) begin
      ep = medge[g] ? (p && !pprev[g]) : p;
      ed = medge[g] ? (d && !dprev[g]) : d;
      pprev[g] = p;
      dprev[g] = d;
      so = 1'b0;
      su = 1'b0;
      sz = mq[g].size();
      if (fl) begin
        mq[g].delete();
      end else if (sz == 0) begin
        if (ep) mq[g].push_back(din);
        if (ed) su = 1'b1;
      end else if (sz == mdepth[g]) begin
        if (ep && ed) begin
          pop_check(g);
          mq[g].push_back(din);
        end else if (ep) so = 1'b1;
        else if (ed) pop_check(g);
      end else begin
        if (ed) pop_check(g);
        if (ep) mq[g].push_back(din);
      end
      movf[g] = so | (movf[g] & !ce);
      munf[g] = su | (munf[g] & !ce);
    end
    @(posedge clk);
    #1;
    post_check();
    if (fl) regout_zero_check("flush_dout");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    push = 1'b0; drop = 1'b0; flush = 1'b0; clear_err = 1'b0; data_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    post_check();
    regout_zero_check("reset_dout");
  endtask

  initial begin
    rst = 1'b0;
    push = 1'b0; drop = 1'b0; flush = 1'b0; clear_err = 1'b0; data_i = '0;
    afull_th  = 4'd4;
    aempty_th = 4'd1;
    do_reset();

    // Fill, overflow, drain in order, underflow, clear
    for (int i = 0; i < 6; i++) step(1, 0, 8'h11 + 8'(i), 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 1);

    // Pointer wrap
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 8'h30 + 8'(i), 0, 0);
      step(0, 1, 8'h00, 0, 0);
    end
    for (int i = 0; i < 4; i++) step(1, 0, 8'hA0 + 8'(i), 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 1);

    // Simultaneous push+drop when full
    for (int i = 0; i < 5; i++) step(1, 0, 8'h60 + 8'(i), 0, 0);
    step(1, 1, 8'h77, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 1);

    // Simultaneous push+drop when empty
    step(0, 0, 8'h00, 0, 0);
    step(1, 1, 8'h42, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 1);

    // Held push and held drop
    for (int i = 0; i < 3; i++) step(1, 0, 8'h5A, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'h00, 0, 0);
      step(0, 1, 8'h00, 0, 0);
    end
    step(0, 0, 8'h00, 0, 1);

    // Flush with push and drop at count 3
    step(1, 0, 8'hC1, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(1, 0, 8'hC2, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(1, 0, 8'hC3, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(1, 1, 8'hEE, 1, 0);
    step(0, 0, 8'h00, 0, 0);

    // Threshold above depth never asserts almost_full
    afull_th = 4'd9;
    for (int i = 0; i < 9; i++) step(1, 0, 8'h80 + 8'(i), 0, 0);
    afull_th = 4'd4;
    for (int i = 0; i < 9; i++) step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 1);

    // Random traffic
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));

    // Asynchronous reset mid-stream
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 8'hD0 + 8'(i), 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    push = 1'b0; drop = 1'b0; flush = 1'b0; clear_err = 1'b0;
    #1;
    model_reset();
    post_check();
    regout_zero_check("async_rst_dout");
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 8'hE5, 0, 0);
    step(0, 1, 8'h00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
